mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 analog mux: steps the select through the enabled channels in
// ascending order, waits SETTLE cycles per channel, then captures mux_out.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_en,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample,
    output logic [3:0] valid
);

    // state   | meaning
    // IDLE    | waiting for start; outputs hold the last scan result
    // SETTLE  | select driven, counting down the settle time
    // CAPTURE | capture edge: store mux_out, advance or finish
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam state_t     ST_AFTER_SEL = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] sample_q, sample_d;
    logic [3:0] valid_q, valid_d;

    // Lowest enabled channel at index >= lo; bit 2 flags whether one exists.
    function automatic logic [2:0] first_from(input logic [3:0] m, input int lo);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && i >= lo) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    logic [2:0] first_ch;
    logic [2:0] next_ch;

    always_comb begin
        first_ch = first_from(ch_en, 0);
        next_ch  = first_from(mask_q, int'(sel_q) + 1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sample_d = 4'b0000;
                    mask_d   = ch_en;
                    valid_d  = ch_en;
                    if (first_ch[2]) begin
                        sel_d   = first_ch[1:0];
                        busy_d  = 1'b1;
                        cnt_d   = SETTLE_CNT;
                        state_d = ST_AFTER_SEL;
                    end else begin
                        // empty mask: report completion without touching the select
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                sample_d[sel_q] = mux_out;
                if (next_ch[2]) begin
                    sel_d   = next_ch[1:0];
                    cnt_d   = SETTLE_CNT;
                    state_d = ST_AFTER_SEL;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            mask_q   <= 4'd0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'd0;
            valid_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign s1     = sel_q[1];
    assign s0     = sel_q[0];
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=0) driven by
// randomized scans and checked cycle by cycle against a channel-list model.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, start0 = 1'b0;
    logic [3:0] en1 = 4'd0, en0 = 4'd0;
    logic [3:0] in1 = 4'd0, in0 = 4'd0;
    logic       s1_1, s0_1, busy1, done1, s1_0, s0_0, busy0, done0;
    logic [3:0] sample1, valid1, sample0, valid0;
    logic       mux1, mux0;

    assign mux1 = in1[{s1_1, s0_1}];
    assign mux0 = in0[{s1_0, s0_0}];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ch_en(en1), .mux_out(mux1),
        .s1(s1_1), .s0(s0_1), .busy(busy1), .done(done1), .sample(sample1), .valid(valid1)
    );

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ch_en(en0), .mux_out(mux0),
        .s1(s1_0), .s0(s0_0), .busy(busy0), .done(done0), .sample(sample0), .valid(valid0)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [1:0] o_sel;
    logic       o_busy, o_done;
    logic [3:0] o_sample, o_valid;

    task automatic snap(input bit d0);
        o_sel    = d0 ? {s1_0, s0_0} : {s1_1, s0_1};
        o_busy   = d0 ? busy0 : busy1;
        o_done   = d0 ? done0 : done1;
        o_sample = d0 ? sample0 : sample1;
        o_valid  = d0 ? valid0 : valid1;
    endtask

    task automatic drive(input bit d0, input logic st, input logic [3:0] en, input logic [3:0] inv);
        if (d0) begin start0 = st; en0 = en; in0 = inv; end
        else    begin start1 = st; en1 = en; in1 = inv; end
    endtask

    task automatic set_start(input bit d0, input logic st);
        if (d0) start0 = st; else start1 = st;
    endtask

    // One full scan; model = ascending list of enabled channels, each held SETTLE+1 edges.
    task automatic scan(input bit d0, input logic [3:0] en, input logic [3:0] inv,
                        input bit disturb, input string tag);
        int ch[$];
        int s, n, lat;
        logic [1:0] sel_before;
        s = d0 ? 0 : 1;
        for (int i = 0; i < 4; i++) if (en[i]) ch.push_back(i);
        n = ch.size();
        lat = n * (s + 1);
        snap(d0);
        sel_before = o_sel;
        drive(d0, 1'b1, en, inv);
        @(posedge clk); #1;
        set_start(d0, 1'b0);
        snap(d0);
        if (n == 0) begin
            total_cnt++;
            if (o_done !== 1'b1 || o_busy !== 1'b0) $display("FAIL %s empty_done: done=%b busy=%b want done=1 busy=0", tag, o_done, o_busy);
            else pass_cnt++;
            total_cnt++;
            if (o_sample !== 4'd0 || o_valid !== 4'd0 || o_sel !== sel_before)
                $display("FAIL %s empty_regs: sample=%b valid=%b sel=%0d want 0000 0000 %0d", tag, o_sample, o_valid, o_sel, sel_before);
            else pass_cnt++;
            @(posedge clk); #1;
            snap(d0);
            total_cnt++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) $display("FAIL %s empty_after: done=%b busy=%b want 0 0", tag, o_done, o_busy);
            else pass_cnt++;
            return;
        end
        for (int k = 0; k < lat; k++) begin
            total_cnt++;
            if (o_sel !== 2'(ch[k / (s + 1)]) || o_busy !== 1'b1 || o_done !== 1'b0)
                $display("FAIL %s step%0d: sel=%0d busy=%b done=%b want sel=%0d busy=1 done=0", tag, k, o_sel, o_busy, o_done, ch[k / (s + 1)]);
            else pass_cnt++;
            if (disturb && k == 1) drive(d0, 1'b1, ~en, inv);
            if (disturb && k == lat - 2) set_start(d0, 1'b0);
            @(posedge clk); #1;
            snap(d0);
        end
        total_cnt++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) $display("FAIL %s done_edge: done=%b busy=%b want 1 0", tag, o_done, o_busy);
        else pass_cnt++;
        total_cnt++;
        if (o_sample !== (en & inv) || o_valid !== en)
            $display("FAIL %s result: sample=%b valid=%b want %b %b", tag, o_sample, o_valid, en & inv, en);
        else pass_cnt++;
        @(posedge clk); #1;
        snap(d0);
        total_cnt++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_sel !== 2'(ch[n - 1]) || o_sample !== (en & inv))
            $display("FAIL %s idle_hold: done=%b busy=%b sel=%0d sample=%b want 0 0 %0d %b", tag, o_done, o_busy, o_sel, o_sample, ch[n - 1], en & inv);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        snap(1'b0);
        total_cnt++;
        if ({o_sel, o_busy, o_done, o_sample, o_valid} !== 12'd0) $display("FAIL reset0: got %h want 000", {o_sel, o_busy, o_done, o_sample, o_valid});
        else pass_cnt++;
        snap(1'b1);
        total_cnt++;
        if ({o_sel, o_busy, o_done, o_sample, o_valid} !== 12'd0) $display("FAIL reset1: got %h want 000", {o_sel, o_busy, o_done, o_sample, o_valid});
        else pass_cnt++;
    endtask

    task automatic test_directed;
        scan(1'b0, 4'b1111, 4'b0101, 1'b0, "full_scan");
        scan(1'b0, 4'b1010, 4'b1010, 1'b0, "sparse_scan");
        scan(1'b0, 4'b0000, 4'b1111, 1'b0, "empty_mask");
        scan(1'b1, 4'b1111, 4'b0110, 1'b0, "settle0_full");
    endtask

    task automatic test_ignored_start;
        scan(1'b0, 4'b1111, 4'b1001, 1'b1, "ignored_start");
        // no second scan may follow: two quiet idle cycles
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            snap(1'b0);
            total_cnt++;
            if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL ignored_quiet%0d: busy=%b done=%b want 0 0", k, o_busy, o_done);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b1, 4'b0101, 4'b0100);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (done1 !== 1'b1) $display("FAIL b2b_done: done=%b want 1", done1);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done1, busy1);
        else pass_cnt++;
        @(posedge clk); #1;
        start1 = 1'b0;
        total_cnt++;
        if (busy1 !== 1'b1 || {s1_1, s0_1} !== 2'd0 || sample1 !== 4'd0)
            $display("FAIL b2b_restart: busy=%b sel=%0d sample=%b want 1 0 0000", busy1, {s1_1, s0_1}, sample1);
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (done1 !== 1'b1 || sample1 !== 4'b0100) $display("FAIL b2b_second: done=%b sample=%b want 1 0100", done1, sample1);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_scan;
        drive(1'b0, 1'b1, 4'b1111, 4'b1111);
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if ({s1_1, s0_1} !== 2'd2 || busy1 !== 1'b1) $display("FAIL mid_pre: sel=%0d busy=%b want 2 1", {s1_1, s0_1}, busy1);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({s1_1, s0_1, busy1, done1, sample1, valid1} !== 12'd0)
            $display("FAIL mid_async: got %h want 000", {s1_1, s0_1, busy1, done1, sample1, valid1});
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        scan(1'b0, 4'b0110, 4'b0010, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        logic [3:0] en, inv;
        for (int t = 0; t < 10; t++) begin
            en  = 4'($urandom_range(0, 15));
            inv = 4'($urandom_range(0, 15));
            scan(t[0], en, inv, 1'($urandom_range(0, 1)) & (en == 4'hF), $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
